// File: rtl/avg_mag_sched_if.sv
// Bus between the symbol-timing strobe source / controller and the
// avg_mag window scheduler. The optional hold input exists only when
// AVG_MAG_SCHED_HOLD_EN is defined.
interface avg_mag_sched_if;
    logic       enable;
    logic       sym_clk_en;
`ifdef AVG_MAG_SCHED_HOLD_EN
    logic       hold;
`endif
    logic       acc_sym_en;
    logic       clr_acc;
    logic       lvl_valid;
    logic       lvl_ok;
    logic       busy;
    logic [7:0] win_cnt;

`ifdef AVG_MAG_SCHED_HOLD_EN
    modport master (
        output enable, sym_clk_en, hold,
        input  acc_sym_en, clr_acc, lvl_valid, lvl_ok, busy, win_cnt
    );
    modport slave (
        input  enable, sym_clk_en, hold,
        output acc_sym_en, clr_acc, lvl_valid, lvl_ok, busy, win_cnt
    );
`else
    modport master (
        output enable, sym_clk_en,
        input  acc_sym_en, clr_acc, lvl_valid, lvl_ok, busy, win_cnt
    );
    modport slave (
        input  enable, sym_clk_en,
        output acc_sym_en, clr_acc, lvl_valid, lvl_ok, busy, win_cnt
    );
`endif
endinterface

// File: rtl/avg_mag_sched.sv
// Window scheduler for the average-magnitude / reference-level datapath.
// Counts symbol strobes, gates the accumulator's symbol enable, issues the
// latch/clear pulse, discards warm-up windows and flags a trustworthy level.
// Optional macro AVG_MAG_SCHED_HOLD_EN adds a hold input that freezes
// accumulation while in ACCUM.
module avg_mag_sched #(
    parameter int WIN_LOG2   = 22,  // log2 symbols per window (ACC_WID-18)
    parameter int CLR_CYC    = 2,   // clr_acc length in clk cycles, 1..15
    parameter int WARMUP_WIN = 1    // windows discarded before lvl_valid, 0..255
) (
    input  logic           clk,
    input  logic           reset,   // asynchronous, active-low
    avg_mag_sched_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    localparam logic [3:0]          CLR_LAST = 4'(CLR_CYC - 1);
    localparam logic [7:0]          WARMUP   = 8'(WARMUP_WIN);
    localparam logic [WIN_LOG2-1:0] SYM_LAST = '1;
    localparam logic [WIN_LOG2-1:0] SYM_ONE  = WIN_LOG2'(1);

    logic [1:0]          r_state;
    logic [WIN_LOG2-1:0] r_sym_cnt;
    logic [3:0]          r_clr_cnt;
    logic [7:0]          r_win_cnt;
    logic                r_acc_sym_en;
    logic                r_clr_acc;
    logic                r_lvl_valid;
    logic                r_lvl_ok;
    logic                r_busy;

    logic                w_hold;
    logic                w_clr_done;
    logic                w_strobe;
    logic [7:0]          w_win_next;
    logic                w_past_warm;

`ifdef AVG_MAG_SCHED_HOLD_EN
    assign w_hold = bus.hold;
`else
    assign w_hold = 1'b0;
`endif

    // A held strobe is treated exactly as if it never arrived.
    assign w_strobe    = bus.sym_clk_en & ~w_hold;
    assign w_clr_done  = (r_clr_cnt == CLR_LAST);
    assign w_win_next  = (r_win_cnt == 8'hFF) ? 8'hFF : r_win_cnt + 8'd1;
    assign w_past_warm = (w_win_next > WARMUP);

    // Scheduler FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_sym_cnt    <= '0;
            r_clr_cnt    <= '0;
            r_win_cnt    <= '0;
            r_acc_sym_en <= 1'b0;
            r_clr_acc    <= 1'b0;
            r_lvl_valid  <= 1'b0;
            r_lvl_ok     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register
            // samples pre-edge values; the default below makes lvl_valid a
            // single-cycle pulse unless a branch re-asserts it.
            r_lvl_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_state   <= S_PRIME;
                        r_win_cnt <= '0;
                        r_clr_cnt <= '0;
                        r_clr_acc <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_PRIME: begin
                    if (!bus.enable) begin
                        r_state      <= S_IDLE;
                        r_clr_acc    <= 1'b0;
                        r_acc_sym_en <= 1'b0;
                        r_busy       <= 1'b0;
                        r_lvl_ok     <= 1'b0;
                    end else if (w_clr_done) begin
                        // A strobe on this edge is ignored; counting starts next clk.
                        r_state   <= S_ACCUM;
                        r_clr_acc <= 1'b0;
                        r_sym_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 4'd1;
                    end
                end
                S_ACCUM: begin
                    if (!bus.enable) begin
                        // Partial window is abandoned; no latch pulse.
                        r_state      <= S_IDLE;
                        r_clr_acc    <= 1'b0;
                        r_acc_sym_en <= 1'b0;
                        r_busy       <= 1'b0;
                        r_lvl_ok     <= 1'b0;
                    end else begin
                        r_acc_sym_en <= w_strobe;
                        if (w_strobe) begin
                            r_sym_cnt <= r_sym_cnt + SYM_ONE;
                            // The closing strobe is still passed on above.
                            if (r_sym_cnt == SYM_LAST) begin
                                r_state   <= S_LATCH;
                                r_clr_acc <= 1'b1;
                                r_clr_cnt <= '0;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    // Strobes here are dropped; the clear pulse is never cut short.
                    r_acc_sym_en <= 1'b0;
                    if (w_clr_done) begin
                        r_win_cnt   <= w_win_next;
                        r_clr_acc   <= 1'b0;
                        r_lvl_valid <= w_past_warm;
                        r_sym_cnt   <= '0;
                        if (bus.enable) begin
                            r_state <= S_ACCUM;
                            if (w_past_warm) begin
                                r_lvl_ok <= 1'b1;
                            end
                        end else begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_lvl_ok <= 1'b0;
                        end
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.acc_sym_en = r_acc_sym_en;
    assign bus.clr_acc    = r_clr_acc;
    assign bus.lvl_valid  = r_lvl_valid;
    assign bus.lvl_ok     = r_lvl_ok;
    assign bus.busy       = r_busy;
    assign bus.win_cnt    = r_win_cnt;
endmodule

// File: tb/tb_avg_mag_sched.sv
// Directed bench for avg_mag_sched with WIN_LOG2=3, CLR_CYC=2, WARMUP_WIN=1
// and a symbol strobe every 4 clk.
module tb_avg_mag_sched;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    avg_mag_sched_if u_if ();

    avg_mag_sched #(
        .WIN_LOG2   (3),
        .CLR_CYC    (2),
        .WARMUP_WIN (1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE: PRIME holds clr_acc 2 clk; a strobe on the
    // PRIME->ACCUM edge must not be counted.
    task automatic start_run();
        u_if.enable = 1'b1;
        tick();
        check("prime_clr_a", u_if.clr_acc, 1);
        check("prime_busy", u_if.busy, 1);
        check("start_win_clr", u_if.win_cnt, 0);
        u_if.sym_clk_en = 1'b1;
        tick();
        check("prime_clr_b", u_if.clr_acc, 1);
        check("prime_acc_off", u_if.acc_sym_en, 0);
        tick();
        u_if.sym_clk_en = 1'b0;
        check("prime_clr_end", u_if.clr_acc, 0);
        check("prime_edge_acc", u_if.acc_sym_en, 0);
    endtask

    // n strobes, one per 4 clk. Reports acc_sym_en pulses, clr_acc-high
    // cycles, lvl_valid pulses and which strobe first raised clr_acc.
    task automatic run_win(input int n, input bit inject, input bit drop,
                           input int hold_lo, input int hold_hi,
                           output int acc, output int clr, output int lv,
                           output int close_idx);
        acc = 0; clr = 0; lv = 0; close_idx = 0;
        for (int i = 1; i <= n; i++) begin
`ifdef AVG_MAG_SCHED_HOLD_EN
            u_if.hold = (i >= hold_lo) && (i < hold_hi);
`endif
            u_if.sym_clk_en = 1'b1;
            for (int t = 0; t < 4; t++) begin
                tick();
                acc += int'(u_if.acc_sym_en);
                lv  += int'(u_if.lvl_valid);
                if (u_if.clr_acc) begin
                    clr++;
                    if (close_idx == 0) close_idx = i;
                end
                if (t == 0) begin
`ifdef AVG_MAG_SCHED_HOLD_EN
                    u_if.hold = 1'b0;
`endif
                    if (i == n && drop) u_if.enable = 1'b0;
                    u_if.sym_clk_en = (i == n) && inject;
                end
                if (t == 2) u_if.sym_clk_en = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, clr, lv, cl;
        int tot_acc, tot_lv;
        reset = 1'b0;
        u_if.enable = 1'b0;
        u_if.sym_clk_en = 1'b0;
`ifdef AVG_MAG_SCHED_HOLD_EN
        u_if.hold = 1'b0;
`endif
        repeat (3) tick();
        check("rst_acc", u_if.acc_sym_en, 0);
        check("rst_clr", u_if.clr_acc, 0);
        check("rst_lv", u_if.lvl_valid, 0);
        check("rst_ok", u_if.lvl_ok, 0);
        check("rst_busy", u_if.busy, 0);
        check("rst_win", u_if.win_cnt, 0);
        reset = 1'b1;
        repeat (2) tick();
        check("idle_busy", u_if.busy, 0);

        // Three-plus windows back to back; window 1 is warm-up.
        start_run();
        run_win(8, 0, 0, 0, 0, acc, clr, lv, cl);
        check("w1_acc", acc, 8); check("w1_clr", clr, 2); check("w1_close", cl, 8);
        check("w1_lv", lv, 0); check("w1_win", u_if.win_cnt, 1); check("w1_ok", u_if.lvl_ok, 0);
        run_win(8, 0, 0, 0, 0, acc, clr, lv, cl);
        check("w2_acc", acc, 8); check("w2_clr", clr, 2); check("w2_close", cl, 8);
        check("w2_lv", lv, 1); check("w2_win", u_if.win_cnt, 2); check("w2_ok", u_if.lvl_ok, 1);
        // Strobes on both LATCH cycles of window 3 must be dropped.
        run_win(8, 1, 0, 0, 0, acc, clr, lv, cl);
        check("w3_acc", acc, 8); check("w3_clr", clr, 2);
        check("w3_lv", lv, 1); check("w3_win", u_if.win_cnt, 3);
        run_win(8, 0, 0, 0, 0, acc, clr, lv, cl);
        check("w4_acc", acc, 8); check("w4_close", cl, 8);
        check("w4_lv", lv, 1); check("w4_win", u_if.win_cnt, 4);

        // Drop enable mid-window after 5 strobes.
        run_win(5, 0, 0, 0, 0, acc, clr, lv, cl);
        check("part_acc", acc, 5); check("part_clr", clr, 0);
        u_if.enable = 1'b0;
        tick();
        check("drop_busy", u_if.busy, 0); check("drop_clr", u_if.clr_acc, 0);
        check("drop_acc", u_if.acc_sym_en, 0); check("drop_ok", u_if.lvl_ok, 0);
        check("drop_win", u_if.win_cnt, 4);
        repeat (3) tick();
        check("drop_lv", u_if.lvl_valid, 0);

        // Asynchronous reset mid-ACCUM with sym_cnt=5.
        start_run();
        run_win(8, 0, 0, 0, 0, acc, clr, lv, cl);
        check("r_w1_win", u_if.win_cnt, 1);
        run_win(5, 0, 0, 0, 0, acc, clr, lv, cl);
        check("r_pre_busy", u_if.busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_busy", u_if.busy, 0); check("ar_win", u_if.win_cnt, 0);
        check("ar_clr", u_if.clr_acc, 0); check("ar_acc", u_if.acc_sym_en, 0);
        reset = 1'b1;
        start_run();
        run_win(8, 0, 0, 0, 0, acc, clr, lv, cl);
        check("ar_w_acc", acc, 8); check("ar_w_close", cl, 8);
        check("ar_w_win", u_if.win_cnt, 1); check("ar_w_lv", lv, 0);

        // Enable dropped on the first LATCH cycle: pulse completes, then IDLE.
        run_win(8, 0, 1, 0, 0, acc, clr, lv, cl);
        check("dl_clr", clr, 2); check("dl_lv", lv, 1);
        check("dl_win", u_if.win_cnt, 2); check("dl_busy", u_if.busy, 0);
        check("dl_ok", u_if.lvl_ok, 0);

        // win_cnt saturation at 255.
        start_run();
        tot_acc = 0; tot_lv = 0;
        for (int w = 0; w < 255; w++) begin
            run_win(8, 0, 0, 0, 0, acc, clr, lv, cl);
            tot_acc += acc;
            tot_lv  += lv;
        end
        check("sat_tot_acc", tot_acc, 2040); check("sat_tot_lv", tot_lv, 254);
        check("sat_win_a", u_if.win_cnt, 255);
        run_win(8, 0, 0, 0, 0, acc, clr, lv, cl);
        check("sat_win_b", u_if.win_cnt, 255); check("sat_lv", lv, 1);
        check("sat_ok", u_if.lvl_ok, 1);

`ifdef AVG_MAG_SCHED_HOLD_EN
        // Hold over strobes 4..6: window closes on the 11th strobe.
        run_win(11, 0, 0, 4, 7, acc, clr, lv, cl);
        check("hold_acc", acc, 8); check("hold_close", cl, 11);
        check("hold_clr", clr, 2); check("hold_lv", lv, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
